// File: rtl/dg_call_stack.sv
// -----------------------------------------------------------------------------
// dg_call_stack
// Parametrised return-address stack for the DG-series 4-bit MCU cores.
// CALL pushes, RET/RETSK pops, push+pop together replaces the top entry.
// ent[0] is the top of stack; ent[DEPTH-1] is the bottom. Every entry at or
// beyond the current occupancy always reads as zero.
//
// Parameters:
//   PC_W     width of one stacked address
//   DEPTH    number of entries (>= 2)
//   CNT_W    occupancy counter width (>= clog2(DEPTH+1))
//   OVF_MODE push-when-full policy: 0 = shift out the oldest entry,
//            1 = reject the push
//
// Ports:
//   clk       core clock, rising edge
//   rst_n     asynchronous active-low reset
//   en        step qualifier; no state change when low (clr_err excepted)
//   push      push pc_in
//   pop       pop the top entry
//   pc_in     address to push
//   clr_err   clears the sticky ovf/unf flags
//   top       combinational view of ent[0]
//   pop_data  registered value removed by the last pop
//   pop_vld   one-cycle pulse aligned with a pop_data update
//   count     number of valid entries, 0..DEPTH
//   empty     count == 0
//   full      count == DEPTH
//   ovf       sticky overflow flag
//   unf       sticky underflow flag
//
// Optional feature (macro DG_STACK_PEEK_EN):
//   peek_idx  entry index to inspect
//   peek_data combinational ent[peek_idx], zero when peek_idx >= DEPTH
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module dg_call_stack #(
  parameter int PC_W     = 10,
  parameter int DEPTH    = 5,
  parameter int CNT_W    = 3,
  parameter int OVF_MODE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             push,
  input  logic             pop,
  input  logic [PC_W-1:0]  pc_in,
  input  logic             clr_err,
`ifdef DG_STACK_PEEK_EN
  input  logic [CNT_W-1:0] peek_idx,
  output logic [PC_W-1:0]  peek_data,
`endif
  output logic [PC_W-1:0]  top,
  output logic [PC_W-1:0]  pop_data,
  output logic             pop_vld,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [PC_W-1:0] ent [DEPTH];

  logic do_push_only;
  logic do_pop_only;
  logic do_replace;
  logic ovf_set;
  logic unf_set;

  assign top   = ent[0];
  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);

  assign do_push_only = en &&  push && !pop;
  assign do_pop_only  = en && !push &&  pop;
  assign do_replace   = en &&  push &&  pop;

  // A replace never overflows; it underflows only when there was nothing to
  // remove, exactly like a plain pop from an empty stack.
  assign ovf_set = do_push_only && full;
  assign unf_set = (do_pop_only || do_replace) && empty;

  // NOTE: the entry array is cleared by the asynchronous reset as well as the
  // control state, so no stale return address can be observed after reset and
  // the "zero beyond count" invariant holds from the first cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      count    <= '0;
      pop_data <= '0;
      pop_vld  <= 1'b0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
    end else begin
      pop_vld <= en && pop;

      // Set has priority over clear; clear works even while en is low.
      ovf <= ovf_set || (ovf && !clr_err);
      unf <= unf_set || (unf && !clr_err);

      if (do_push_only) begin
        // When full with the reject policy the stack is left untouched.
        if (!full || OVF_MODE == 0) begin
          for (int i = DEPTH - 1; i > 0; i--) ent[i] <= ent[i-1];
          ent[0] <= pc_in;
          if (!full) count <= count + ONE_C;
        end
      end

      if (do_pop_only) begin
        // ent[0] is already zero when empty, so pop_data reads back 0.
        pop_data <= ent[0];
        for (int i = 0; i < DEPTH - 1; i++) ent[i] <= ent[i+1];
        ent[DEPTH-1] <= '0;
        if (!empty) count <= count - ONE_C;
      end

      if (do_replace) begin
        pop_data <= ent[0];
        ent[0]   <= pc_in;
        if (empty) count <= ONE_C;
      end
    end
  end

`ifdef DG_STACK_PEEK_EN
  // NOTE: every combinational output gets a default before the selection loop
  // so an out-of-range index yields zero instead of inferring a latch.
  always_comb begin
    peek_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (peek_idx == CNT_W'(i)) peek_data = ent[i];
    end
  end
`endif

endmodule

// File: tb/tb_dg_call_stack.sv
`timescale 1ns/1ps

module tb_dg_call_stack;

  localparam int PC_W  = 10;
  localparam int DEPTH = 5;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en, push, pop, clr_err;
  logic [PC_W-1:0]  pc_in;

  // Index 0: OVF_MODE=0 instance, index 1: OVF_MODE=1 instance.
  logic [PC_W-1:0]  top      [2];
  logic [PC_W-1:0]  pop_data [2];
  logic             pop_vld  [2];
  logic [CNT_W-1:0] count    [2];
  logic             empty    [2];
  logic             full     [2];
  logic             ovf      [2];
  logic             unf      [2];

`ifdef DG_STACK_PEEK_EN
  logic [CNT_W-1:0] peek_idx;
  logic [PC_W-1:0]  peek_data [2];
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: a queue per instance, element 0 is the top of stack.
  logic [PC_W-1:0] mq   [2][$];
  logic [PC_W-1:0] m_pd [2];
  logic            m_pv;
  logic            m_ovf [2];
  logic            m_unf [2];

  always #5 clk = ~clk;

  dg_call_stack #(.PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .OVF_MODE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .push(push), .pop(pop), .pc_in(pc_in),
    .clr_err(clr_err),
`ifdef DG_STACK_PEEK_EN
    .peek_idx(peek_idx), .peek_data(peek_data[0]),
`endif
    .top(top[0]), .pop_data(pop_data[0]), .pop_vld(pop_vld[0]), .count(count[0]),
    .empty(empty[0]), .full(full[0]), .ovf(ovf[0]), .unf(unf[0])
  );

  dg_call_stack #(.PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .OVF_MODE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .push(push), .pop(pop), .pc_in(pc_in),
    .clr_err(clr_err),
`ifdef DG_STACK_PEEK_EN
    .peek_idx(peek_idx), .peek_data(peek_data[1]),
`endif
    .top(top[1]), .pop_data(pop_data[1]), .pop_vld(pop_vld[1]), .count(count[1]),
    .empty(empty[1]), .full(full[1]), .ovf(ovf[1]), .unf(unf[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mq[m].delete();
      m_pd[m]  = '0;
      m_ovf[m] = 1'b0;
      m_unf[m] = 1'b0;
    end
    m_pv = 1'b0;
  endtask

  task automatic model_step(input logic e, input logic p, input logic o,
                            input logic [PC_W-1:0] pc, input logic c);
    for (int m = 0; m < 2; m++) begin
      logic so, su;
      so = 1'b0;
      su = 1'b0;
      if (e && p && !o) begin
        if (mq[m].size() < DEPTH) mq[m].push_front(pc);
        else begin
          so = 1'b1;
          if (m == 0) begin
            void'(mq[m].pop_back());
            mq[m].push_front(pc);
          end
        end
      end else if (e && o && !p) begin
        if (mq[m].size() == 0) begin su = 1'b1; m_pd[m] = '0; end
        else m_pd[m] = mq[m].pop_front();
      end else if (e && o && p) begin
        if (mq[m].size() == 0) begin
          su = 1'b1;
          m_pd[m] = '0;
          mq[m].push_front(pc);
        end else begin
          m_pd[m] = mq[m][0];
          mq[m][0] = pc;
        end
      end
      m_ovf[m] = so || (m_ovf[m] && !c);
      m_unf[m] = su || (m_unf[m] && !c);
    end
    m_pv = e && o;
  endtask

  task automatic check_all(input string tag);
    for (int m = 0; m < 2; m++) begin
      logic [PC_W-1:0] exp_top;
      exp_top = (mq[m].size() != 0) ? mq[m][0] : '0;
      check($sformatf("%s_m%0d_top", tag, m),      32'(top[m]),      32'(exp_top));
      check($sformatf("%s_m%0d_count", tag, m),    32'(count[m]),    32'(mq[m].size()));
      check($sformatf("%s_m%0d_empty", tag, m),    32'(empty[m]),    32'(mq[m].size() == 0));
      check($sformatf("%s_m%0d_full", tag, m),     32'(full[m]),     32'(mq[m].size() == DEPTH));
      check($sformatf("%s_m%0d_ovf", tag, m),      32'(ovf[m]),      32'(m_ovf[m]));
      check($sformatf("%s_m%0d_unf", tag, m),      32'(unf[m]),      32'(m_unf[m]));
      check($sformatf("%s_m%0d_pop_vld", tag, m),  32'(pop_vld[m]),  32'(m_pv));
      check($sformatf("%s_m%0d_pop_data", tag, m), 32'(pop_data[m]), 32'(m_pd[m]));
`ifdef DG_STACK_PEEK_EN
      begin
        logic [PC_W-1:0] exp_pk;
        exp_pk = (int'(peek_idx) < mq[m].size()) ? mq[m][int'(peek_idx)] : '0;
        check($sformatf("%s_m%0d_peek", tag, m), 32'(peek_data[m]), 32'(exp_pk));
      end
`endif
    end
  endtask

  // Drive on the falling edge, sample 1 ns after the rising edge.
  task automatic step(input logic e, input logic p, input logic o,
                      input logic [PC_W-1:0] pc, input logic c);
    @(negedge clk);
    en = e; push = p; pop = o; pc_in = pc; clr_err = c;
    @(posedge clk);
    #1;
    model_step(e, p, o, pc, c);
    check_all("step");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0; pc_in = '0;
    #1;
    model_reset();
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0; pc_in = '0;
`ifdef DG_STACK_PEEK_EN
    peek_idx = '0;
`endif
    model_reset();
    #1;
    check_all("por");
    check("por_top_const", 32'(top[0]), 32'h0);
    check("por_empty_const", 32'(empty[0]), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic push/pop.
    step(1, 1, 0, 10'h101, 0);
    step(1, 1, 0, 10'h202, 0);
    step(1, 1, 0, 10'h303, 0);
    check("tp1_top", 32'(top[0]), 32'h303);
    check("tp1_count", 32'(count[0]), 32'd3);
    step(1, 0, 1, '0, 0);
    check("tp1_pop_data", 32'(pop_data[0]), 32'h303);
    check("tp1_pop_vld", 32'(pop_vld[0]), 32'h1);
    check("tp1_top_after", 32'(top[0]), 32'h202);
    step(0, 0, 0, '0, 0);
    check("tp1_vld_drop", 32'(pop_vld[0]), 32'h0);

    // Overflow under both policies.
    do_reset();
    for (int i = 1; i <= 6; i++) step(1, 1, 0, 10'(i), 0);
    check("ovf0_top", 32'(top[0]), 32'h006);
    check("ovf0_full", 32'(full[0]), 32'h1);
    check("ovf0_flag", 32'(ovf[0]), 32'h1);
    check("ovf1_top", 32'(top[1]), 32'h005);
    check("ovf1_flag", 32'(ovf[1]), 32'h1);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 1, '0, 0);
      check($sformatf("ovf0_pop%0d", i), 32'(pop_data[0]), 32'(6 - i));
    end
    step(1, 0, 0, '0, 1);
    check("ovf1_clr", 32'(ovf[1]), 32'h0);

    // Underflow, replace on empty, clear colliding with a new underflow.
    do_reset();
    step(1, 0, 1, '0, 0);
    check("unf_flag", 32'(unf[0]), 32'h1);
    check("unf_pop_data", 32'(pop_data[0]), 32'h0);
    step(1, 1, 1, 10'h3FF, 0);
    check("unf_rep_count", 32'(count[0]), 32'd1);
    check("unf_rep_top", 32'(top[0]), 32'h3FF);
    step(1, 0, 1, '0, 0);
    step(1, 0, 1, '0, 1);
    check("unf_set_wins", 32'(unf[0]), 32'h1);

    // Replace, enable gating, mid-cycle reset.
    do_reset();
    step(1, 1, 0, 10'h055, 0);
    step(1, 1, 0, 10'h0AA, 0);
    step(1, 1, 1, 10'h155, 0);
    check("rep_pop_data", 32'(pop_data[0]), 32'h0AA);
    check("rep_top", 32'(top[0]), 32'h155);
    check("rep_count", 32'(count[0]), 32'd2);
    step(0, 1, 0, 10'h123, 0);
    check("en0_top", 32'(top[0]), 32'h155);
    check("en0_count", 32'(count[0]), 32'd2);
    step(1, 0, 1, '0, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("midrst");
    @(negedge clk);
    rst_n = 1'b1;

`ifdef DG_STACK_PEEK_EN
    step(1, 1, 0, 10'h010, 0);
    step(1, 1, 0, 10'h020, 0);
    peek_idx = 3'd1; #1;
    check("peek1", 32'(peek_data[0]), 32'h010);
    peek_idx = 3'd4; #1;
    check("peek4", 32'(peek_data[0]), 32'h0);
    peek_idx = 3'd7; #1;
    check("peek7", 32'(peek_data[0]), 32'h0);
`endif

    // Randomised traffic against the queue model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      logic e, p, o, c;
      e = ($urandom_range(0, 9) != 0);
      p = $urandom_range(0, 1) == 1;
      o = $urandom_range(0, 1) == 1;
      c = ($urandom_range(0, 15) == 0);
`ifdef DG_STACK_PEEK_EN
      peek_idx = CNT_W'($urandom_range(0, 7));
`endif
      step(e, p, o, 10'($urandom), c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
